// File: rtl/cpu_ctrl_pkg.sv
// =============================================================================
// Module      : cpu_ctrl_pkg
// Description : State encoding, opcode/ALUop and datapath select constants
//               shared by the CPU controller and its memory wait timer.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package cpu_ctrl_pkg;

    typedef logic [4:0] state_t;

    localparam state_t C_ST_WAIT   = 5'd0;
    localparam state_t C_ST_GET_A  = 5'd1;
    localparam state_t C_ST_GET_B  = 5'd2;
    localparam state_t C_ST_ALU    = 5'd3;
    localparam state_t C_ST_WR     = 5'd4;
    localparam state_t C_ST_CMP    = 5'd5;
    localparam state_t C_ST_ALU_Z  = 5'd6;
    localparam state_t C_ST_MOVI   = 5'd7;
    localparam state_t C_ST_ADDR   = 5'd8;
    localparam state_t C_ST_LADDR  = 5'd9;
    localparam state_t C_ST_MEM_RD = 5'd10;
    localparam state_t C_ST_MEM_WB = 5'd11;
    localparam state_t C_ST_GET_D  = 5'd12;
    localparam state_t C_ST_DATA   = 5'd13;
    localparam state_t C_ST_MEM_WR = 5'd14;
    localparam state_t C_ST_HALT   = 5'd15;
    localparam state_t C_ST_NOP    = 5'd16;
    localparam state_t C_ST_TRAP   = 5'd17;

    localparam logic [2:0] C_OP_LDR  = 3'b011;
    localparam logic [2:0] C_OP_STR  = 3'b100;
    localparam logic [2:0] C_OP_ALU  = 3'b101;
    localparam logic [2:0] C_OP_MOV  = 3'b110;
    localparam logic [2:0] C_OP_HALT = 3'b111;

    localparam logic [1:0] C_ALU_ADD = 2'b00;
    localparam logic [1:0] C_ALU_CMP = 2'b01;
    localparam logic [1:0] C_ALU_AND = 2'b10;
    localparam logic [1:0] C_ALU_MVN = 2'b11;
    localparam logic [1:0] C_MOV_REG = 2'b00;
    localparam logic [1:0] C_MOV_IMM = 2'b10;
    localparam logic [1:0] C_MEM_SUB = 2'b00;

    localparam logic [2:0] C_NSEL_RM = 3'b000;
    localparam logic [2:0] C_NSEL_RD = 3'b001;
    localparam logic [2:0] C_NSEL_RN = 3'b010;

    localparam logic [1:0] C_VSEL_C      = 2'b00;
    localparam logic [1:0] C_VSEL_SXIMM8 = 2'b10;
    localparam logic [1:0] C_VSEL_MDATA  = 2'b11;

    // First state of each instruction; illegal encodings map to NOP and the
    // controller decides whether that becomes a trap.
    function automatic state_t first_state(input logic [2:0] op, input logic [1:0] alu);
        state_t st;
        st = C_ST_NOP;
        case (op)
            C_OP_ALU:  st = (alu == C_ALU_MVN) ? C_ST_GET_B : C_ST_GET_A;
            C_OP_MOV: begin
                if (alu == C_MOV_REG)      st = C_ST_GET_B;
                else if (alu == C_MOV_IMM) st = C_ST_MOVI;
            end
            C_OP_LDR:  if (alu == C_MEM_SUB) st = C_ST_GET_A;
            C_OP_STR:  if (alu == C_MEM_SUB) st = C_ST_GET_A;
            C_OP_HALT: st = C_ST_HALT;
            default:   st = C_ST_NOP;
        endcase
        return st;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_ctrl_fsm_mem_wait_timer.sv
// =============================================================================
// Module      : mem_wait_timer
// Description : Saturating count of not-ready cycles during a memory access;
//               flags a timeout on the cycle the count would reach MEM_TIMEOUT.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic ready,
    output logic timeout
);

    generate
        if (MEM_TIMEOUT == 0) begin : g_disabled
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst, clear, enable, ready};
            assign timeout  = 1'b0;
        end else begin : g_counter
            localparam int C_W = $clog2(MEM_TIMEOUT + 1);
            localparam logic [C_W-1:0] C_LIMIT = C_W'(MEM_TIMEOUT);
            localparam logic [C_W-1:0] C_LAST  = C_W'(MEM_TIMEOUT - 1);
            localparam logic [C_W-1:0] C_ONE   = C_W'(1);

            logic [C_W-1:0] r_count;

            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    r_count <= '0;
                end else if (enable && !ready && (r_count != C_LIMIT)) begin
                    r_count <= r_count + C_ONE;
                end
            end

            // A ready in the same cycle always wins over the timeout.
            assign timeout = enable && !ready && (r_count == C_LAST);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/cpu_ctrl_fsm.sv
// =============================================================================
// Module      : cpu_ctrl_fsm
// Description : Moore controller sequencing register-file/ALU strobes and the
//               memory handshake. Define CPU_CTRL_ILLEGAL_TRAP_EN to trap on
//               illegal instructions and memory timeouts.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] ALUop,
    input  logic       mem_ready,
    output logic       W,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       load_addr,
    output logic       mem_req,
    output logic       mem_write,
    output logic       halted,
    output logic       trap
);

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    localparam state_t C_FAULT_STATE = C_ST_TRAP;
`else
    localparam state_t C_FAULT_STATE = C_ST_WAIT;
`endif

    state_t     r_state;
    state_t     w_next;
    state_t     w_first;
    logic [2:0] r_opcode;
    logic [1:0] r_alu_op;
    logic       w_in_mem;
    logic       w_timeout;
    logic       w_is_ldr;
    logic       w_is_cmp;
    logic       w_is_two_op;

    assign w_in_mem    = (r_state == C_ST_MEM_RD) || (r_state == C_ST_MEM_WR);
    assign w_is_ldr    = (r_opcode == C_OP_LDR);
    assign w_is_cmp    = (r_opcode == C_OP_ALU) && (r_alu_op == C_ALU_CMP);
    assign w_is_two_op = (r_opcode == C_OP_ALU) &&
                         ((r_alu_op == C_ALU_ADD) || (r_alu_op == C_ALU_AND));

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (reset),
        .clear   (!w_in_mem),
        .enable  (w_in_mem),
        .ready   (mem_ready),
        .timeout (w_timeout)
    );

    // The decode register only changes on the WAIT exit edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= C_ST_WAIT;
            r_opcode <= '0;
            r_alu_op <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == C_ST_WAIT) && s) begin
                r_opcode <= opcode;
                r_alu_op <= ALUop;
            end
        end
    end

    always_comb begin
        w_first = first_state(opcode, ALUop);
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        if (w_first == C_ST_NOP) w_first = C_ST_TRAP;
`endif
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            C_ST_WAIT:   if (s) w_next = w_first;
            C_ST_GET_A:  w_next = (r_opcode == C_OP_ALU) ? C_ST_GET_B : C_ST_ADDR;
            C_ST_GET_B:  w_next = w_is_cmp ? C_ST_CMP : (w_is_two_op ? C_ST_ALU : C_ST_ALU_Z);
            C_ST_ALU:    w_next = C_ST_WR;
            C_ST_ALU_Z:  w_next = C_ST_WR;
            C_ST_ADDR:   w_next = C_ST_LADDR;
            C_ST_LADDR:  w_next = w_is_ldr ? C_ST_MEM_RD : C_ST_GET_D;
            C_ST_GET_D:  w_next = C_ST_DATA;
            C_ST_DATA:   w_next = C_ST_MEM_WR;
            C_ST_MEM_RD: begin
                if (mem_ready)      w_next = C_ST_MEM_WB;
                else if (w_timeout) w_next = C_FAULT_STATE;
            end
            C_ST_MEM_WR: begin
                if (mem_ready)      w_next = C_ST_WAIT;
                else if (w_timeout) w_next = C_FAULT_STATE;
            end
            C_ST_HALT:   w_next = C_ST_HALT;
            C_ST_TRAP:   w_next = C_ST_TRAP;
            default:     w_next = C_ST_WAIT;
        endcase
    end

    always_comb begin
        W         = 1'b0;
        nsel      = C_NSEL_RM;
        vsel      = C_VSEL_C;
        write     = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        load_addr = 1'b0;
        mem_req   = 1'b0;
        mem_write = 1'b0;
        halted    = 1'b0;
        trap      = 1'b0;
        case (r_state)
            C_ST_WAIT:   W = 1'b1;
            C_ST_GET_A:  begin nsel = C_NSEL_RN; loada = 1'b1; end
            C_ST_GET_B:  begin nsel = C_NSEL_RM; loadb = 1'b1; end
            C_ST_ALU:    loadc = 1'b1;
            C_ST_WR:     begin nsel = C_NSEL_RD; vsel = C_VSEL_C; write = 1'b1; end
            C_ST_CMP:    loads = 1'b1;
            C_ST_ALU_Z:  begin asel = 1'b1; loadc = 1'b1; end
            C_ST_MOVI:   begin nsel = C_NSEL_RN; vsel = C_VSEL_SXIMM8; write = 1'b1; end
            C_ST_ADDR:   begin bsel = 1'b1; loadc = 1'b1; end
            C_ST_LADDR:  load_addr = 1'b1;
            C_ST_MEM_RD: mem_req = 1'b1;
            C_ST_MEM_WB: begin nsel = C_NSEL_RD; vsel = C_VSEL_MDATA; write = 1'b1; end
            C_ST_GET_D:  begin nsel = C_NSEL_RD; loadb = 1'b1; end
            C_ST_DATA:   begin asel = 1'b1; loadc = 1'b1; end
            C_ST_MEM_WR: begin mem_req = 1'b1; mem_write = 1'b1; end
            C_ST_HALT:   halted = 1'b1;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
            C_ST_TRAP:   trap = 1'b1;
`endif
            default:     ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_ctrl_fsm.sv
// =============================================================================
// Module      : tb_cpu_ctrl_fsm
// Description : Scoreboard bench for cpu_ctrl_fsm (MEM_TIMEOUT=4); follows
//               CPU_CTRL_ILLEGAL_TRAP_EN when choosing fault expectations.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_cpu_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic [1:0] ALUop = 2'b00;
    logic       mem_ready = 1'b0;
    logic       W, write, loada, loadb, loadc, loads, asel, bsel;
    logic       load_addr, mem_req, mem_write, halted, trap;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic [17:0] outv;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       rst;
        logic       s;
        logic [2:0] op;
        logic [1:0] alu;
        logic       rdy;
        string      st;
    } item_t;

    item_t sb[$];

    always #5 clk = ~clk;

    cpu_ctrl_fsm #(.MEM_TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .s         (s),
        .opcode    (opcode),
        .ALUop     (ALUop),
        .mem_ready (mem_ready),
        .W         (W),
        .nsel      (nsel),
        .vsel      (vsel),
        .write     (write),
        .loada     (loada),
        .loadb     (loadb),
        .loadc     (loadc),
        .loads     (loads),
        .asel      (asel),
        .bsel      (bsel),
        .load_addr (load_addr),
        .mem_req   (mem_req),
        .mem_write (mem_write),
        .halted    (halted),
        .trap      (trap)
    );

    assign outv = {W, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
                   load_addr, mem_req, mem_write, halted, trap};

    // Output model: {W,nsel,vsel,write,loada,loadb,loadc,loads,asel,bsel,laddr,req,wr,halt,trap}
    function automatic logic [17:0] expv(input string st);
        logic w, wr, la, lb, lc, ls, as, bs, ld, rq, mw, h, t;
        logic [2:0] ns;
        logic [1:0] vs;
        {w, wr, la, lb, lc, ls, as, bs, ld, rq, mw, h, t} = '0;
        ns = 3'b000;
        vs = 2'b00;
        case (st)
            "WAIT":   w = 1'b1;
            "GET_A":  begin ns = 3'b010; la = 1'b1; end
            "GET_B":  begin ns = 3'b000; lb = 1'b1; end
            "ALU":    lc = 1'b1;
            "WR":     begin ns = 3'b001; vs = 2'b00; wr = 1'b1; end
            "CMP":    ls = 1'b1;
            "ALU_Z":  begin as = 1'b1; lc = 1'b1; end
            "MOVI":   begin ns = 3'b010; vs = 2'b10; wr = 1'b1; end
            "ADDR":   begin bs = 1'b1; lc = 1'b1; end
            "LADDR":  ld = 1'b1;
            "MEM_RD": rq = 1'b1;
            "MEM_WB": begin ns = 3'b001; vs = 2'b11; wr = 1'b1; end
            "GET_D":  begin ns = 3'b001; lb = 1'b1; end
            "DATA":   begin as = 1'b1; lc = 1'b1; end
            "MEM_WR": begin rq = 1'b1; mw = 1'b1; end
            "HALT":   h = 1'b1;
            "TRAP":   t = 1'b1;
            "NOP":    ;
            default:  return 'x;
        endcase
        return {w, ns, vs, wr, la, lb, lc, ls, as, bs, ld, rq, mw, h, t};
    endfunction

    task automatic push(input logic r, input logic sv, input logic [2:0] op,
                        input logic [1:0] al, input logic rd, input string st);
        item_t it;
        it.rst = r; it.s = sv; it.op = op; it.alu = al; it.rdy = rd; it.st = st;
        sb.push_back(it);
    endtask

    task automatic test_reset();
        item_t it;
        push(1, 0, 3'b101, 2'b00, 0, "WAIT");
        push(1, 1, 3'b101, 2'b00, 1, "WAIT");
        push(0, 0, 3'b101, 2'b00, 0, "WAIT");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            reset = it.rst; s = it.s; opcode = it.op; ALUop = it.alu; mem_ready = it.rdy;
            @(posedge clk); #1;
            n_checks++;
            if (outv !== expv(it.st)) begin
                n_fail++;
                $display("FAIL reset/%s: got %b expected %b", it.st, outv, expv(it.st));
            end
        end
    endtask

    task automatic test_alu_ops();
        item_t it;
        // ADD with the opcode inputs scrambled after launch
        push(0, 1, 3'b101, 2'b00, 0, "GET_A");
        push(0, 0, 3'b111, 2'b11, 0, "GET_B");
        push(0, 0, 3'b000, 2'b01, 0, "ALU");
        push(0, 0, 3'b000, 2'b01, 0, "WR");
        push(0, 0, 3'b000, 2'b01, 0, "WAIT");
        // MVN
        push(0, 1, 3'b101, 2'b11, 0, "GET_B");
        push(0, 0, 3'b101, 2'b00, 0, "ALU_Z");
        push(0, 0, 3'b101, 2'b00, 0, "WR");
        push(0, 0, 3'b101, 2'b00, 0, "WAIT");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            reset = it.rst; s = it.s; opcode = it.op; ALUop = it.alu; mem_ready = it.rdy;
            @(posedge clk); #1;
            n_checks++;
            if (outv !== expv(it.st)) begin
                n_fail++;
                $display("FAIL alu_ops/%s: got %b expected %b", it.st, outv, expv(it.st));
            end
        end
    endtask

    task automatic test_back_to_back();
        item_t it;
        // CMP then MOV imm with s held high throughout
        push(0, 1, 3'b101, 2'b01, 0, "GET_A");
        push(0, 1, 3'b110, 2'b10, 0, "GET_B");
        push(0, 1, 3'b110, 2'b10, 0, "CMP");
        push(0, 1, 3'b110, 2'b10, 0, "WAIT");
        push(0, 1, 3'b110, 2'b10, 0, "MOVI");
        push(0, 0, 3'b110, 2'b10, 0, "WAIT");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            reset = it.rst; s = it.s; opcode = it.op; ALUop = it.alu; mem_ready = it.rdy;
            @(posedge clk); #1;
            n_checks++;
            if (outv !== expv(it.st)) begin
                n_fail++;
                $display("FAIL back_to_back/%s: got %b expected %b", it.st, outv, expv(it.st));
            end
        end
    endtask

    task automatic test_ldr();
        item_t it;
        push(1, 0, 3'b000, 2'b00, 0, "WAIT");
        push(0, 1, 3'b011, 2'b00, 0, "GET_A");
        push(0, 0, 3'b011, 2'b00, 0, "ADDR");
        push(0, 0, 3'b011, 2'b00, 0, "LADDR");
        push(0, 0, 3'b011, 2'b00, 0, "MEM_RD");
        push(0, 0, 3'b011, 2'b00, 0, "MEM_RD");
        push(0, 0, 3'b011, 2'b00, 0, "MEM_RD");
        push(0, 0, 3'b011, 2'b00, 0, "MEM_RD");
        // ready on the same cycle the timer would expire
        push(0, 0, 3'b011, 2'b00, 1, "MEM_WB");
        push(0, 0, 3'b011, 2'b00, 0, "WAIT");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            reset = it.rst; s = it.s; opcode = it.op; ALUop = it.alu; mem_ready = it.rdy;
            @(posedge clk); #1;
            n_checks++;
            if (outv !== expv(it.st)) begin
                n_fail++;
                $display("FAIL ldr/%s: got %b expected %b", it.st, outv, expv(it.st));
            end
        end
    endtask

    task automatic test_str_timeout();
        item_t it;
        string fault;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        fault = "TRAP";
`else
        fault = "WAIT";
`endif
        push(1, 0, 3'b000, 2'b00, 0, "WAIT");
        push(0, 1, 3'b100, 2'b00, 0, "GET_A");
        push(0, 0, 3'b100, 2'b00, 0, "ADDR");
        push(0, 0, 3'b100, 2'b00, 0, "LADDR");
        push(0, 0, 3'b100, 2'b00, 0, "GET_D");
        push(0, 0, 3'b100, 2'b00, 0, "DATA");
        push(0, 0, 3'b100, 2'b00, 0, "MEM_WR");
        push(0, 0, 3'b100, 2'b00, 0, "MEM_WR");
        push(0, 0, 3'b100, 2'b00, 0, "MEM_WR");
        push(0, 0, 3'b100, 2'b00, 0, "MEM_WR");
        push(0, 0, 3'b100, 2'b00, 0, fault);
        push(0, 0, 3'b100, 2'b00, 0, fault);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            reset = it.rst; s = it.s; opcode = it.op; ALUop = it.alu; mem_ready = it.rdy;
            @(posedge clk); #1;
            n_checks++;
            if (outv !== expv(it.st)) begin
                n_fail++;
                $display("FAIL str_timeout/%s: got %b expected %b", it.st, outv, expv(it.st));
            end
        end
    endtask

    task automatic test_illegal();
        item_t it;
        push(1, 0, 3'b000, 2'b00, 0, "WAIT");
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        push(0, 1, 3'b000, 2'b00, 0, "TRAP");
        push(0, 0, 3'b101, 2'b00, 0, "TRAP");
        push(0, 1, 3'b101, 2'b00, 1, "TRAP");
`else
        push(0, 1, 3'b000, 2'b00, 0, "NOP");
        push(0, 0, 3'b000, 2'b00, 0, "WAIT");
        push(0, 1, 3'b110, 2'b01, 0, "NOP");
        push(0, 0, 3'b110, 2'b01, 0, "WAIT");
`endif
        while (sb.size() > 0) begin
            it = sb.pop_front();
            reset = it.rst; s = it.s; opcode = it.op; ALUop = it.alu; mem_ready = it.rdy;
            @(posedge clk); #1;
            n_checks++;
            if (outv !== expv(it.st)) begin
                n_fail++;
                $display("FAIL illegal/%s: got %b expected %b", it.st, outv, expv(it.st));
            end
        end
    endtask

    task automatic test_reset_abort();
        item_t it;
        push(1, 0, 3'b000, 2'b00, 0, "WAIT");
        push(0, 1, 3'b101, 2'b00, 0, "GET_A");
        push(0, 0, 3'b101, 2'b00, 0, "GET_B");
        push(1, 0, 3'b101, 2'b00, 0, "WAIT");
        push(0, 0, 3'b101, 2'b00, 0, "WAIT");
        push(0, 0, 3'b101, 2'b00, 0, "WAIT");
        push(0, 1, 3'b011, 2'b00, 0, "GET_A");
        push(0, 0, 3'b011, 2'b00, 0, "ADDR");
        push(0, 0, 3'b011, 2'b00, 0, "LADDR");
        push(0, 0, 3'b011, 2'b00, 0, "MEM_RD");
        push(0, 0, 3'b011, 2'b00, 0, "MEM_RD");
        push(1, 0, 3'b011, 2'b00, 1, "WAIT");
        push(0, 0, 3'b011, 2'b00, 0, "WAIT");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            reset = it.rst; s = it.s; opcode = it.op; ALUop = it.alu; mem_ready = it.rdy;
            @(posedge clk); #1;
            n_checks++;
            if (outv !== expv(it.st)) begin
                n_fail++;
                $display("FAIL reset_abort/%s: got %b expected %b", it.st, outv, expv(it.st));
            end
        end
    endtask

    task automatic test_halt();
        item_t it;
        push(1, 0, 3'b000, 2'b00, 0, "WAIT");
        push(0, 1, 3'b111, 2'b10, 0, "HALT");
        push(0, 0, 3'b101, 2'b00, 0, "HALT");
        push(0, 1, 3'b110, 2'b10, 0, "HALT");
        push(0, 0, 3'b011, 2'b00, 1, "HALT");
        push(0, 1, 3'b000, 2'b00, 0, "HALT");
        push(1, 0, 3'b000, 2'b00, 0, "WAIT");
        push(0, 0, 3'b000, 2'b00, 0, "WAIT");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            reset = it.rst; s = it.s; opcode = it.op; ALUop = it.alu; mem_ready = it.rdy;
            @(posedge clk); #1;
            n_checks++;
            if (outv !== expv(it.st)) begin
                n_fail++;
                $display("FAIL halt/%s: got %b expected %b", it.st, outv, expv(it.st));
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_back_to_back();
        test_ldr();
        test_str_timeout();
        test_illegal();
        test_reset_abort();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_ctrl_fsm.md
# cpu_ctrl_fsm

Parametrised successor to the single-cycle-decode CPU controller: a Moore state machine that sequences the register-file and ALU datapath control strobes for ALU, MOV, LDR, STR and HALT instructions. It adds a memory request/ready handshake with a bounded wait timer, a sticky halt state and an optional illegal-instruction trap. It sits between the instruction register and the datapath/memory interface in the CPU top level.

## Interface
- MEM_TIMEOUT, 15: maximum cycles spent waiting for `mem_ready`; 0 means wait indefinitely.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- s  in  1  start request, sampled only in WAIT.
- opcode  in  3  instruction opcode from the instruction register.
- ALUop  in  2  ALU operation / sub-opcode.
- mem_ready  in  1  memory completes the current request this cycle.
- W  out  1  controller idle in WAIT.
- nsel  out  3  register select: 000 Rm, 001 Rd, 010 Rn.
- vsel  out  2  writeback source: 00 C, 10 sximm8, 11 mdata.
- write  out  1  register-file write enable.
- loada, loadb, loadc, loads  out  1 each  A, B, C and status register load enables.
- asel  out  1  1 forces the ALU A input to zero.
- bsel  out  1  1 selects sximm5 as the ALU B input.
- load_addr  out  1  load the data-address register from C.
- mem_req  out  1  memory request, held until acknowledged or timed out.
- mem_write  out  1  1 = store, 0 = load; valid only while `mem_req` is high.
- halted  out  1  controller is in HALT.
- trap  out  1  controller is in TRAP.

## Operation
- On exit from WAIT, `opcode` and `ALUop` are latched into an internal decode register. Later changes to the inputs have no effect until the controller returns to WAIT.
- All outputs are a Moore decode of the current state. Every strobe not listed for a state is 0.
- WAIT: W=1. If s=1, latch the decode and go to the first state of the sequence below; otherwise stay.
- ADD (101/00) and AND (101/10): GET_A (nsel=Rn, loada) → GET_B (nsel=Rm, loadb) → ALU (asel=0, bsel=0, loadc) → WR (nsel=Rd, vsel=C, write) → WAIT.
- CMP (101/01): GET_A → GET_B → CMP (asel=0, bsel=0, loads) → WAIT.
- MVN (101/11) and MOV reg (110/00): GET_B → ALU_Z (asel=1, loadc) → WR → WAIT.
- MOV imm (110/10): MOVI (nsel=Rn, vsel=sximm8, write) → WAIT.
- LDR (011/00): GET_A → ADDR (bsel=1, loadc) → LADDR (load_addr) → MEM_RD (mem_req, mem_write=0) → MEM_WB (nsel=Rd, vsel=mdata, write) → WAIT.
- STR (100/00): GET_A → ADDR → LADDR → GET_D (nsel=Rd, loadb) → DATA (asel=1, loadc) → MEM_WR (mem_req, mem_write=1) → WAIT.
- HALT (111, any ALUop): HALT state, halted=1, W=0. Only reset leaves HALT.
- Illegal instruction: any other opcode/ALUop combination. Its handling is set by the configuration macro.
- Memory wait:
  - A timer clears on entry to MEM_RD or MEM_WR and counts each cycle with mem_ready=0.
  - mem_ready=1 exits the state on that edge, to MEM_WB for a load and to WAIT for a store.
  - When the count reaches MEM_TIMEOUT with no ready, the access is a timeout.
  - If mem_ready and the timeout occur in the same cycle, ready wins.

## Timing
- Reset:
  - On any edge with reset=1, the state goes to WAIT, the decode register clears and the timer clears.
  - Outputs after that edge: W=1, all other outputs 0.
  - Reset mid-sequence, including during a MEM state, aborts at that edge. mem_req is 0 from the next cycle.
- Instruction latency (first strobe to return to WAIT):
  - ADD/AND: 4 cycles. CMP: 3. MVN/MOV reg: 3. MOV imm: 1.
  - LDR: 5 + wait cycles. STR: 6 + wait cycles.
- One WAIT cycle (W=1) always separates consecutive instructions, even with s held high.
- mem_req rises on entry to a MEM state and stays high through the ready cycle. It is never high for two consecutive accesses without an intervening non-MEM state.
- Timer width is $clog2(MEM_TIMEOUT+1). The timer saturates and never wraps. With MEM_TIMEOUT=0 the timer is disabled.

## Configuration
- CPU_CTRL_ILLEGAL_TRAP_EN defined:
  - An illegal instruction or a memory timeout goes to TRAP (trap=1, W=0).
  - TRAP is held until reset.
- Not defined:
  - An illegal instruction spends one cycle in a NOP state with no strobes, then returns to WAIT.
  - A memory timeout returns to WAIT with no writeback.
  - The trap port is tied to 0.

## Structure
- Package cpu_ctrl_pkg holds:
  - the state enum;
  - opcode/ALUop localparams;
  - nsel and vsel encodings.
- One sub-module, mem_wait_timer: a parametrised saturating counter with inputs clear, enable and ready, and a timeout output.

## Test plan
- Reset held 2 cycles, then released → W=1, all strobes 0. Drive ADD with s=1 → GET_A/GET_B/ALU/WR strobes on consecutive cycles with nsel 010/000/–/001, then W=1.
- CMP followed immediately by MOV imm, s held high → loads=1 on cycle 3, W=1 for exactly one cycle, then write=1 with nsel=010 and vsel=10.
- LDR with mem_ready asserted 3 cycles after mem_req rises → mem_req high for 4 cycles, mem_write=0, then write=1 with vsel=11 and nsel=001.
- STR with MEM_TIMEOUT=4 and mem_ready never asserted → mem_req high 4 cycles, mem_write=1. Then TRAP (macro on) or W=1 with no write (macro off).
- Opcode 000 with s=1 → trap=1 and held (macro on), or one idle cycle then W=1 (macro off). HALT opcode 111 → halted=1 and held while s toggles.
- Reset asserted during GET_B of ADD and during MEM_RD → next cycle W=1, mem_req=0, write never asserted.
